fs_accel_psum_pack: RTL and testbench
=====================================

Name: fs_accel_psum_pack

Overview:
Downstream consumer of the bypass buffer output. Each cycle it takes one signed MAC result and adds the buffered bias/partial sum (bpbuf_do) to it. The sum is then requantized: rounding arithmetic shift, optional ReLU, and saturation to int8. Four consecutive bytes are packed into a 32-bit word and presented on a valid/ready port for the write-back stage.

Parameters:
ACC_W, 32, width of mac_data and bpbuf_do (signed two's complement).
OUT_W, 8, width of one quantized output lane. Lanes per word = 32/OUT_W = 4; other values are not supported.

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
enb  input  1  global stage enable; low freezes all state
bpbuf_do  input  32  signed bias/partial sum from the bypass buffer, sampled with each accepted MAC
mac_valid  input  1  MAC result valid
mac_ready  output  1  block can accept a MAC result
mac_data  input  32  signed MAC result
cfg_relu  input  1  1 = clamp negative results to 0
cfg_shift  input  5  right-shift amount, 0..31
cfg_flush  input  1  one-cycle pulse; emit a partially filled word
out_valid  output  1  packed word valid
out_ready  input  1  downstream accepts word
out_data  output  32  packed word, lane0 = bits[7:0]
out_bmask  output  4  byte-valid mask for out_data
busy  output  1  stage register, pack register or a pending flush is non-empty

Behaviour:
- Reset (async, resetn=0) clears to 0: out_valid, out_data, out_bmask, lane counter, stage register, flush_pend, busy. mac_ready also reads 0. Asserting reset mid-word discards partial bytes; no output is produced for them.
- enb=0 holds every register and forces mac_ready=0. out_valid/out_data stay stable, and out_ready is ignored while enb=0.
- stall = out_valid & ~out_ready. mac_ready = enb & ~stall.
- A MAC is accepted when mac_valid & mac_ready.
- Stage 1 (registered, 1 cycle):
  - s = sext34(mac_data) + sext34(bpbuf_do).
  - If cfg_shift>0, add 1<<(cfg_shift-1) (round half up), then arithmetic shift right by cfg_shift.
  - If cfg_relu and the result is <0, the result becomes 0.
  - Saturate to [-128,127]. Result goes to s1_byte with s1_valid=1.
- Stage 2: while s1_valid and ~stall, write s1_byte into lane[lane_cnt] and set the matching mask bit.
  - When lane_cnt==3, the completed word moves to out_data with out_bmask=4'hF and out_valid=1 in the same edge, the pack register clears, and lane_cnt wraps to 0.
  - Otherwise lane_cnt increments.
- Stall freezes stage 1 and stage 2 together; no data is lost or duplicated.
- Output: out_valid clears on the edge where out_ready=1 (with enb=1). A new word may load on that same edge, giving back-to-back words with no bubble.
- Latency: the 4th accepted MAC produces out_valid 2 cycles after its acceptance edge (stage 1 edge, then pack edge).
- Flush handling:
  - cfg_flush sets flush_pend.
  - flush_pend is serviced on the first enabled cycle with s1_valid=0, ~stall, and no MAC being accepted. Servicing emits the pack register with out_bmask = the lanes filled so far, unfilled lanes 0. It then clears lane_cnt and flush_pend.
  - If lane_cnt==0 when serviced, the flush is a no-op: flush_pend clears and no word is emitted.
  - If a flush coincides with the 4th byte completing, the full word is emitted and the flush becomes a no-op.
  - While flush_pend=1, mac_ready is held 0 so the flush boundary is exact.
- cfg_shift and cfg_relu are sampled at MAC acceptance. Changing them mid-word is legal and affects only later bytes.

Test Plan:
- Basic pack: bpbuf_do=0, shift=0, relu=0; MACs 1,2,3,4 back-to-back with out_ready=1 -> one word out_data=0x04030201, bmask=0xF, out_valid 2 cycles after the 4th accept.
- Quantize: bpbuf_do=100, mac_data=0x0000_0300 (768), shift=4 -> (868+8)>>4 = 54 = 0x36. mac_data=-2000, shift=2, relu=0 -> saturates to 0x80. Same input with relu=1 -> 0x00. mac_data=0x7FFF_FFFF, bpbuf_do=0x7FFF_FFFF, shift=0 -> 0x7F (no wrap).
- Backpressure: out_ready=0 after the first word, keep mac_valid=1 -> mac_ready drops to 0 and holds. Release out_ready -> second word 0x08070605 follows with no lost or duplicated byte.
- Flush: 2 MACs (0x11, 0x22), then cfg_flush -> out_data=0x00002211, bmask=0x3. A flush with an empty pack register emits nothing and busy returns to 0.
- Enable/reset: enb=0 mid-word with out_valid=1 -> all outputs frozen. Assert resetn=0 asynchronously between clock edges -> out_valid, out_bmask, busy go 0 immediately. The next 4 MACs form a fresh word starting at lane0.

Source files
------------

// File: rtl/fs_accel_psum_pack.sv
// rtl/fs_accel_psum_pack.sv - psum add, requantize to int8, pack four lanes into a 32-bit word
module fs_accel_psum_pack #(
   parameter int ACC_W = 32,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enb,
   input  logic [ACC_W-1:0] bpbuf_do,
   input  logic             mac_valid,
   output logic             mac_ready,
   input  logic [ACC_W-1:0] mac_data,
   input  logic             cfg_relu,
   input  logic [4:0]       cfg_shift,
   input  logic             cfg_flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [3:0]       out_bmask,
   output logic             busy
);

   localparam int LANES  = 32 / OUT_W;
   localparam int LANE_W = $clog2(LANES);
   localparam int SUM_W  = ACC_W + 2;
   localparam int PACK_W = (LANES - 1) * OUT_W;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
   localparam logic signed [SUM_W-1:0] Q_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] Q_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic              s1_valid;
   logic [OUT_W-1:0]  s1_byte;
   logic [LANE_W-1:0] lane_cnt;
   logic [PACK_W-1:0] pack;
   logic              flush_pend;

   logic signed [SUM_W-1:0] sum;
   logic signed [SUM_W-1:0] rnd;
   logic signed [SUM_W-1:0] shifted;
   logic signed [SUM_W-1:0] clipped;
   logic [OUT_W-1:0]        q_byte;
   logic [3:0]              fill_mask;

   logic stall;
   logic accept;
   logic advance;
   logic pack_wr;
   logic word_done;
   logic flush_svc;
   logic flush_emit;

   assign stall      = out_valid & ~out_ready;
   assign mac_ready  = resetn & enb & ~stall & ~flush_pend;
   assign accept     = mac_valid & mac_ready;
   assign advance    = enb & ~stall;
   assign pack_wr    = advance & s1_valid;
   assign word_done  = pack_wr & (lane_cnt == LAST_LANE);
   // a flush only drains once the stage register is empty, so the boundary is exact
   assign flush_svc  = advance & flush_pend & ~s1_valid & ~accept;
   assign flush_emit = flush_svc & (lane_cnt != '0);
   assign busy       = s1_valid | (lane_cnt != '0) | flush_pend;

   always_comb begin
      sum     = {{2{mac_data[ACC_W-1]}}, mac_data} + {{2{bpbuf_do[ACC_W-1]}}, bpbuf_do};
      rnd     = '0;
      if (cfg_shift != 5'd0)
         rnd = {{(SUM_W-1){1'b0}}, 1'b1} << (cfg_shift - 5'd1);
      shifted = (sum + rnd) >>> cfg_shift;
      clipped = shifted;
      if (cfg_relu && shifted < 0)
         clipped = '0;
      if (clipped > Q_MAX)
         q_byte = Q_MAX[OUT_W-1:0];
      else if (clipped < Q_MIN)
         q_byte = Q_MIN[OUT_W-1:0];
      else
         q_byte = clipped[OUT_W-1:0];
   end

   always_comb begin
      fill_mask = 4'h0;
      case (lane_cnt)
         2'd1:    fill_mask = 4'h1;
         2'd2:    fill_mask = 4'h3;
         2'd3:    fill_mask = 4'h7;
         default: fill_mask = 4'h0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid   <= 1'b0;
         s1_byte    <= '0;
         lane_cnt   <= '0;
         pack       <= '0;
         flush_pend <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_bmask  <= '0;
      end else if (enb) begin
         if (!stall) begin
            s1_valid <= accept;
            if (accept)
               s1_byte <= q_byte;
         end

         if (pack_wr) begin
            if (lane_cnt == LAST_LANE) begin
               pack     <= '0;
               lane_cnt <= '0;
            end else begin
               for (int i = 0; i < LANES - 1; i++)
                  if (lane_cnt == LANE_W'(i))
                     pack[i*OUT_W +: OUT_W] <= s1_byte;
               lane_cnt <= lane_cnt + 1'b1;
            end
         end else if (flush_svc) begin
            pack     <= '0;
            lane_cnt <= '0;
         end

         if (cfg_flush)
            flush_pend <= 1'b1;
         else if (flush_svc)
            flush_pend <= 1'b0;

         // loading a new word takes priority over retiring the old one
         if (word_done) begin
            out_valid <= 1'b1;
            out_data  <= {s1_byte, pack};
            out_bmask <= 4'hF;
         end else if (flush_emit) begin
            out_valid <= 1'b1;
            out_data  <= {{OUT_W{1'b0}}, pack};
            out_bmask <= fill_mask;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fs_accel_psum_pack.sv
// tb/tb_fs_accel_psum_pack.sv - directed bench for fs_accel_psum_pack
module tb_fs_accel_psum_pack;

   logic        clk;
   logic        resetn;
   logic        enb;
   logic [31:0] bpbuf_do;
   logic        mac_valid;
   logic        mac_ready;
   logic [31:0] mac_data;
   logic        cfg_relu;
   logic [4:0]  cfg_shift;
   logic        cfg_flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_bmask;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   fs_accel_psum_pack #(.ACC_W(32), .OUT_W(8)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .enb       (enb),
      .bpbuf_do  (bpbuf_do),
      .mac_valid (mac_valid),
      .mac_ready (mac_ready),
      .mac_data  (mac_data),
      .cfg_relu  (cfg_relu),
      .cfg_shift (cfg_shift),
      .cfg_flush (cfg_flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_bmask (out_bmask),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // holds mac_valid high until the handshake completes, bounded
   task automatic send(input logic [31:0] d);
      logic acc;
      acc = 1'b0;
      mac_valid = 1'b1;
      mac_data  = d;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         acc = mac_ready;
         tick();
         if (acc) break;
      end
      check("send_accept", {31'b0, acc}, 32'h1);
   endtask

   initial begin
      resetn = 1'b0; enb = 1'b1; bpbuf_do = '0; mac_valid = 1'b0; mac_data = '0;
      cfg_relu = 1'b0; cfg_shift = 5'd0; cfg_flush = 1'b0; out_ready = 1'b1;
      tick(); tick();
      check("rst_out_valid", {31'b0, out_valid}, 32'h0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_bmask", {28'b0, out_bmask}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_mac_ready", {31'b0, mac_ready}, 32'h0);
      resetn = 1'b1;
      #1;
      check("post_rst_mac_ready", {31'b0, mac_ready}, 32'h1);

      // basic pack and latency
      send(32'd1); send(32'd2); send(32'd3); send(32'd4);
      mac_valid = 1'b0;
      check("basic_not_yet", {31'b0, out_valid}, 32'h0);
      tick();
      check("basic_valid", {31'b0, out_valid}, 32'h1);
      check("basic_data", out_data, 32'h04030201);
      check("basic_bmask", {28'b0, out_bmask}, 32'hF);
      tick();
      check("basic_retired", {31'b0, out_valid}, 32'h0);
      check("basic_idle", {31'b0, busy}, 32'h0);

      // quantization lanes
      bpbuf_do = 32'd100; cfg_shift = 5'd4; send(32'h0000_0300);
      bpbuf_do = 32'd0; cfg_shift = 5'd2; send(-32'sd2000);
      cfg_relu = 1'b1; send(-32'sd2000);
      cfg_relu = 1'b0; cfg_shift = 5'd0; bpbuf_do = 32'h7FFF_FFFF; send(32'h7FFF_FFFF);
      mac_valid = 1'b0; bpbuf_do = '0;
      tick();
      check("quant_valid", {31'b0, out_valid}, 32'h1);
      check("quant_data", out_data, 32'h7F00_8036);
      tick();

      // backpressure
      out_ready = 1'b0;
      send(32'd1); send(32'd2); send(32'd3); send(32'd4); send(32'd5);
      mac_data = 32'd6;
      check("bp_valid", {31'b0, out_valid}, 32'h1);
      check("bp_ready_low", {31'b0, mac_ready}, 32'h0);
      tick(); tick(); tick();
      check("bp_ready_held", {31'b0, mac_ready}, 32'h0);
      check("bp_data_held", out_data, 32'h04030201);
      check("bp_busy", {31'b0, busy}, 32'h1);
      out_ready = 1'b1;
      send(32'd6);
      check("bp_no_dup", {31'b0, out_valid}, 32'h0);
      send(32'd7); send(32'd8);
      mac_valid = 1'b0;
      tick();
      check("bp_word2_valid", {31'b0, out_valid}, 32'h1);
      check("bp_word2_data", out_data, 32'h08070605);
      tick();

      // partial flush
      send(32'h11); send(32'h22);
      mac_valid = 1'b0;
      cfg_flush = 1'b1;
      tick();
      cfg_flush = 1'b0;
      check("flush_hold_ready", {31'b0, mac_ready}, 32'h0);
      check("flush_busy", {31'b0, busy}, 32'h1);
      tick();
      check("flush_valid", {31'b0, out_valid}, 32'h1);
      check("flush_data", out_data, 32'h0000_2211);
      check("flush_bmask", {28'b0, out_bmask}, 32'h3);
      check("flush_idle", {31'b0, busy}, 32'h0);
      tick();

      // flush with nothing packed
      cfg_flush = 1'b1;
      tick();
      cfg_flush = 1'b0;
      check("eflush_pend", {31'b0, busy}, 32'h1);
      tick();
      check("eflush_no_word", {31'b0, out_valid}, 32'h0);
      check("eflush_idle", {31'b0, busy}, 32'h0);

      // enable freeze then async reset mid-word
      out_ready = 1'b0;
      send(32'd1); send(32'd2); send(32'd3); send(32'd4); send(32'd5);
      mac_valid = 1'b0;
      enb = 1'b0; out_ready = 1'b1;
      #1;
      check("enb_ready_low", {31'b0, mac_ready}, 32'h0);
      tick(); tick();
      check("enb_valid_frozen", {31'b0, out_valid}, 32'h1);
      check("enb_data_frozen", out_data, 32'h04030201);
      check("enb_bmask_frozen", {28'b0, out_bmask}, 32'hF);
      check("enb_busy_frozen", {31'b0, busy}, 32'h1);
      #2 resetn = 1'b0;
      #1;
      check("arst_valid", {31'b0, out_valid}, 32'h0);
      check("arst_bmask", {28'b0, out_bmask}, 32'h0);
      check("arst_busy", {31'b0, busy}, 32'h0);
      check("arst_data", out_data, 32'h0);
      tick();
      resetn = 1'b1; enb = 1'b1; out_ready = 1'b1;
      send(32'h0A); send(32'h0B); send(32'h0C); send(32'h0D);
      mac_valid = 1'b0;
      tick();
      check("fresh_valid", {31'b0, out_valid}, 32'h1);
      check("fresh_data", out_data, 32'h0D0C0B0A);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
